cga_isa_bridge: RTL and testbench

- Upstream of the CGA adapter. Converts single-beat CPU-side memory/IO requests from the mcl86 core into ISA-style strobed bus cycles.
- Drives bus address, data and strobes (ior/iow/memr/memw, aen) into the adapter, samples returned read data, and acknowledges the CPU.
- Sequences address setup, strobe width and hold with programmable counts, and stretches the strobe while the target deasserts ready.

---
 rtl/cga_isa_bridge_if.sv | 42 ++++
 rtl/cga_isa_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_cga_isa_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cga_isa_bridge_if.sv
// CPU-side request/ack and ISA-side strobed bus bundle for cga_isa_bridge.
// slave = bridge view, master = CPU/target view.
interface cga_isa_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_io;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_err;
  logic        busy;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        bus_ior_l;
  logic        bus_iow_l;
  logic        bus_memr_l;
  logic        bus_memw_l;
  logic        bus_aen;
  logic [7:0]  bus_in;
  logic        bus_rdy;

  modport slave (
    input  cpu_req, cpu_we, cpu_io,
    input  cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_err, busy,
    output bus_a, bus_d, bus_aen,
    output bus_ior_l, bus_iow_l,
    output bus_memr_l, bus_memw_l,
    input  bus_in, bus_rdy
  );

  modport master (
    output cpu_req, cpu_we, cpu_io,
    output cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_err, busy,
    input  bus_a, bus_d, bus_aen,
    input  bus_ior_l, bus_iow_l,
    input  bus_memr_l, bus_memw_l,
    output bus_in, bus_rdy
  );
endinterface

// File: rtl/cga_isa_bridge.sv
// CPU single-beat request to ISA strobed bus cycle bridge (setup/strobe/hold).
// Optional macro BRIDGE_TIMEOUT_EN: bounded ready-low wait with cpu_err.
module cga_isa_bridge #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 6,
  parameter int HOLD_CYCLES   = 1
`ifdef BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input logic            clk,
  input logic            reset_n,
  cga_isa_bridge_if.slave bif
);

  localparam int SC = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
  localparam int TC = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
  localparam int HC = (HOLD_CYCLES < 0) ? 0 : HOLD_CYCLES;
  localparam logic [7:0] S_LD = 8'(SC - 1);
  localparam logic [7:0] T_LD = 8'(TC - 1);
  localparam logic [7:0] H_LD = (HC > 0) ? 8'(HC - 1) : 8'd0;
`ifdef BRIDGE_TIMEOUT_EN
  localparam int OC = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam logic [7:0] O_LD = 8'(OC - 1);
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, WAIT, HOLD, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [19:0] a_q, a_d;
  logic [7:0]  dat_q, dat_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic        ior_q, ior_d;
  logic        iow_q, iow_d;
  logic        memr_q, memr_d;
  logic        memw_q, memw_d;
  logic        aen_q, aen_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rl_q, rl_d;
  logic        fin;
`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0]  tcnt_q, tcnt_d;
  logic        to_q, to_d;
  logic        err_q, err_d;
`endif

  assign bif.bus_a      = a_q;
  assign bif.bus_d      = dat_q;
  assign bif.bus_ior_l  = ior_q;
  assign bif.bus_iow_l  = iow_q;
  assign bif.bus_memr_l = memr_q;
  assign bif.bus_memw_l = memw_q;
  assign bif.bus_aen    = aen_q;
  assign bif.cpu_ack    = ack_q;
  assign bif.cpu_rdata  = rdata_q;
  assign bif.busy       = (state_q != IDLE);
`ifdef BRIDGE_TIMEOUT_EN
  assign bif.cpu_err    = err_q;
`else
  assign bif.cpu_err    = 1'b0;
`endif

  // Next-state and next-output logic for the bus cycle sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    dat_d   = dat_q;
    we_d    = we_q;
    io_d    = io_q;
    ior_d   = ior_q;
    iow_d   = iow_q;
    memr_d  = memr_q;
    memw_d  = memw_q;
    aen_d   = aen_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    rl_d    = rl_q;
    fin     = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    to_d    = to_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bif.cpu_req) begin
          a_d     = bif.cpu_addr;
          dat_d   = bif.cpu_wdata;
          we_d    = bif.cpu_we;
          io_d    = bif.cpu_io;
          aen_d   = 1'b0;
          cnt_d   = S_LD;
          state_d = SETUP;
`ifdef BRIDGE_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end
      SETUP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          unique case (1'b1)
            io_q && we_q:   iow_d  = 1'b0;
            io_q && !we_q:  ior_d  = 1'b0;
            !io_q && we_q:  memw_d = 1'b0;
            default:        memr_d = 1'b0;
          endcase
          cnt_d   = T_LD;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (bif.bus_rdy) begin
          fin = 1'b1;
        end else begin
          state_d = WAIT;
`ifdef BRIDGE_TIMEOUT_EN
          tcnt_d  = 8'd0;
`endif
        end
      end
      WAIT: begin
        if (bif.bus_rdy) begin
          fin = 1'b1;
        end
`ifdef BRIDGE_TIMEOUT_EN
        else if (tcnt_q == O_LD) begin
          fin  = 1'b1;
          to_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
`endif
      end
      HOLD: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else state_d = DONE;
      end
      DONE: begin
        ack_d   = 1'b1;
        aen_d   = 1'b1;
        state_d = IDLE;
        if (!we_q) rdata_d = rl_q;
`ifdef BRIDGE_TIMEOUT_EN
        err_d   = to_q;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      ior_d  = 1'b1;
      iow_d  = 1'b1;
      memr_d = 1'b1;
      memw_d = 1'b1;
      if (!we_q) rl_d = bif.bus_in;
`ifdef BRIDGE_TIMEOUT_EN
      if (to_d && !we_q) rl_d = 8'hFF;
`endif
      if (HC == 0) begin
        state_d = DONE;
      end else begin
        state_d = HOLD;
        cnt_d   = H_LD;
      end
    end
  end

  // Sequencer state, bus drive and CPU response registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      a_q     <= 20'd0;
      dat_q   <= 8'd0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      memr_q  <= 1'b1;
      memw_q  <= 1'b1;
      aen_q   <= 1'b1;
      ack_q   <= 1'b0;
      rdata_q <= 8'd0;
      rl_q    <= 8'd0;
`ifdef BRIDGE_TIMEOUT_EN
      tcnt_q  <= 8'd0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      io_q    <= io_d;
      ior_q   <= ior_d;
      iow_q   <= iow_d;
      memr_q  <= memr_d;
      memw_q  <= memw_d;
      aen_q   <= aen_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      rl_q    <= rl_d;
`ifdef BRIDGE_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_cga_isa_bridge.sv
// Self-checking bench for cga_isa_bridge: randomized bus cycles
// compared against a cycle-count model of setup/strobe/hold timing.
module tb_cga_isa_bridge;

  localparam int S  = 2;
  localparam int ST = 6;
  localparam int H  = 1;
`ifdef BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [7:0] exp_rdata;

  cga_isa_bridge_if bif ();

  cga_isa_bridge #(
    .SETUP_CYCLES(S),
    .STROBE_CYCLES(ST),
    .HOLD_CYCLES(H)
`ifdef BRIDGE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bif(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ack_idx;
    int ack_cnt;
    int strb_first;
    int strb_low;
    int other_low;
    int aen_low;
    int busy_hi;
    int addr_bad;
    int err_stray;
    logic [7:0] rdata;
    logic err;
  } obs_t;

  // ack sample index after the req-sampling edge
  function automatic int latency(input int k);
    return S + ST + k + H + 1;
  endfunction

  // Plays one CPU cycle and a target that holds ready low for k clocks
  // past the strobe minimum (or forever when stuck); records observations.
  task automatic run_txn(input bit we, input bit io,
                         input logic [19:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input int k,
                         input bit stuck, output obs_t o);
    int base;
    int lim;
    int j;
    logic sel;
    int nlow;
    base = S + ST;
    lim = base + k + H + 6;
    o.ack_idx = -1; o.ack_cnt = 0; o.strb_first = -1;
    o.strb_low = 0; o.other_low = 0; o.aen_low = 0;
    o.busy_hi = 0; o.addr_bad = 0; o.err_stray = 0;
    o.rdata = 8'h00; o.err = 1'b0;
    @(negedge clk);
    bif.cpu_we = we; bif.cpu_io = io;
    bif.cpu_addr = a; bif.cpu_wdata = wd;
    bif.cpu_req = 1'b1;
    bif.bus_rdy = 1'b1; bif.bus_in = ~din;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      bif.cpu_req = 1'b0;
      sel = io ? (we ? bif.bus_iow_l : bif.bus_ior_l)
               : (we ? bif.bus_memw_l : bif.bus_memr_l);
      nlow = 4 - int'(bif.bus_iow_l) - int'(bif.bus_ior_l)
               - int'(bif.bus_memw_l) - int'(bif.bus_memr_l);
      if (!sel) begin
        if (o.strb_first < 0) o.strb_first = i;
        o.strb_low++;
        nlow--;
      end
      if (nlow != 0) o.other_low++;
      if (!bif.bus_aen) begin
        o.aen_low++;
        if (bif.bus_a !== a || (we && bif.bus_d !== wd)) o.addr_bad++;
      end
      if (bif.busy) o.busy_hi++;
      if (bif.cpu_ack) begin
        o.ack_cnt++;
        if (o.ack_idx < 0) o.ack_idx = i;
        o.rdata = bif.cpu_rdata;
        o.err = bif.cpu_err;
      end else if (bif.cpu_err) begin
        o.err_stray++;
      end
      j = i + 1;
      bif.bus_rdy = stuck ? !(j >= base) : !(j >= base && j < base + k);
      bif.bus_in = (!stuck && j == base + k) ? din : ~din;
    end
    bif.bus_rdy = 1'b1;
    bif.bus_in = 8'h00;
  endtask

  task automatic test_reset;
    checks++;
    if ({bif.bus_ior_l, bif.bus_iow_l, bif.bus_memr_l, bif.bus_memw_l} !== 4'hF) begin
      errors++; $display("FAIL reset_strobes: got %b want 1111",
        {bif.bus_ior_l, bif.bus_iow_l, bif.bus_memr_l, bif.bus_memw_l});
    end
    checks++;
    if (bif.bus_aen !== 1'b1 || bif.busy !== 1'b0) begin
      errors++; $display("FAIL reset_aen_busy: got %b%b want 10", bif.bus_aen, bif.busy);
    end
    checks++;
    if (bif.bus_a !== 20'h0 || bif.bus_d !== 8'h0) begin
      errors++; $display("FAIL reset_bus: got %h/%h want 0/0", bif.bus_a, bif.bus_d);
    end
    checks++;
    if (bif.cpu_ack !== 1'b0 || bif.cpu_err !== 1'b0 || bif.cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_cpu: got %b %b %h want 0 0 00",
        bif.cpu_ack, bif.cpu_err, bif.cpu_rdata);
    end
  endtask

  task automatic test_mem_write;
    obs_t o;
    run_txn(1'b1, 1'b0, 20'hB8000, 8'h41, 8'h00, 0, 1'b0, o);
    checks++;
    if (o.strb_first != S || o.strb_low != ST) begin
      errors++; $display("FAIL memw_strobe: got first %0d len %0d want %0d %0d",
        o.strb_first, o.strb_low, S, ST);
    end
    checks++;
    if (o.ack_idx != latency(0) || o.ack_cnt != 1) begin
      errors++; $display("FAIL memw_ack: got idx %0d cnt %0d want %0d 1",
        o.ack_idx, o.ack_cnt, latency(0));
    end
    checks++;
    if (o.aen_low != latency(0) || o.addr_bad != 0 || o.other_low != 0) begin
      errors++; $display("FAIL memw_bus: got aen %0d bad %0d other %0d want %0d 0 0",
        o.aen_low, o.addr_bad, o.other_low, latency(0));
    end
    checks++;
    if (o.rdata !== exp_rdata) begin
      errors++; $display("FAIL memw_rdata_hold: got %h want %h", o.rdata, exp_rdata);
    end
  endtask

  task automatic test_io_read;
    obs_t o;
    run_txn(1'b0, 1'b1, 20'h003DA, 8'h00, 8'hF9, 0, 1'b0, o);
    exp_rdata = 8'hF9;
    checks++;
    if (o.strb_low != ST || o.other_low != 0) begin
      errors++; $display("FAIL ior_strobe: got len %0d other %0d want %0d 0",
        o.strb_low, o.other_low, ST);
    end
    checks++;
    if (o.ack_idx != latency(0) || o.rdata !== exp_rdata) begin
      errors++; $display("FAIL ior_data: got idx %0d data %h want %0d %h",
        o.ack_idx, o.rdata, latency(0), exp_rdata);
    end
  endtask

  task automatic test_wait_states;
    obs_t o;
    logic [7:0] din;
    din = 8'($urandom);
    run_txn(1'b0, 1'b0, 20'($urandom), 8'h00, din, 5, 1'b0, o);
    exp_rdata = din;
    checks++;
    if (o.strb_low != ST + 5) begin
      errors++; $display("FAIL wait_strobe: got %0d want %0d", o.strb_low, ST + 5);
    end
    checks++;
    if (o.ack_idx != latency(5) || o.busy_hi != latency(5)) begin
      errors++; $display("FAIL wait_ack: got idx %0d busy %0d want %0d",
        o.ack_idx, o.busy_hi, latency(5));
    end
    checks++;
    if (o.rdata !== exp_rdata) begin
      errors++; $display("FAIL wait_data: got %h want %h", o.rdata, exp_rdata);
    end
  endtask

`ifdef BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    obs_t o;
    run_txn(1'b0, 1'b0, 20'h12345, 8'h00, 8'h5A, TO, 1'b1, o);
    exp_rdata = 8'hFF;
    checks++;
    if (o.strb_low != ST + TO) begin
      errors++; $display("FAIL timeout_strobe: got %0d want %0d", o.strb_low, ST + TO);
    end
    checks++;
    if (o.ack_idx != latency(TO) || o.err !== 1'b1 || o.err_stray != 0) begin
      errors++; $display("FAIL timeout_ack: got idx %0d err %b stray %0d want %0d 1 0",
        o.ack_idx, o.err, o.err_stray, latency(TO));
    end
    checks++;
    if (o.rdata !== exp_rdata) begin
      errors++; $display("FAIL timeout_data: got %h want %h", o.rdata, exp_rdata);
    end
  endtask
`endif

  task automatic test_random;
    obs_t o;
    bit we, io;
    int k;
    logic [19:0] a;
    logic [7:0] wd, din;
    for (int n = 0; n < 12; n++) begin
      we = 1'($urandom); io = 1'($urandom);
      k = int'($urandom_range(0, 3));
      a = 20'($urandom); wd = 8'($urandom); din = 8'($urandom);
      run_txn(we, io, a, wd, din, k, 1'b0, o);
      if (!we) exp_rdata = din;
      checks++;
      if (o.strb_first != S || o.strb_low != ST + k || o.other_low != 0) begin
        errors++; $display("FAIL rand%0d_strobe: got %0d/%0d/%0d want %0d/%0d/0",
          n, o.strb_first, o.strb_low, o.other_low, S, ST + k);
      end
      checks++;
      if (o.ack_idx != latency(k) || o.ack_cnt != 1 || o.aen_low != latency(k)) begin
        errors++; $display("FAIL rand%0d_ack: got %0d/%0d/%0d want %0d/1/%0d",
          n, o.ack_idx, o.ack_cnt, o.aen_low, latency(k), latency(k));
      end
      checks++;
      if (o.rdata !== exp_rdata || o.addr_bad != 0) begin
        errors++; $display("FAIL rand%0d_data: got %h bad %0d want %h 0",
          n, o.rdata, o.addr_bad, exp_rdata);
      end
      checks++;
      if (o.err !== 1'b0 || o.err_stray != 0) begin
        errors++; $display("FAIL rand%0d_err: got %b/%0d want 0/0", n, o.err, o.err_stray);
      end
    end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    int acks;
    acks = 0;
    @(negedge clk);
    bif.cpu_we = 1'b1; bif.cpu_io = 1'b1;
    bif.cpu_addr = 20'h003D4; bif.cpu_wdata = 8'h0E;
    bif.cpu_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bif.cpu_req = 1'b0;
    end
    checks++;
    if (bif.bus_iow_l !== 1'b0) begin
      errors++; $display("FAIL rstmid_pre: got iow_l %b want 0", bif.bus_iow_l);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bif.bus_iow_l !== 1'b1 || bif.bus_aen !== 1'b1 || bif.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got iow %b aen %b busy %b want 1 1 0",
        bif.bus_iow_l, bif.bus_aen, bif.busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_rdata = 8'h00;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bif.cpu_ack) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL rstmid_noack: got %0d want 0", acks);
    end
    run_txn(1'b1, 1'b1, 20'h003D4, 8'h0E, 8'h00, 0, 1'b0, o);
    checks++;
    if (o.ack_idx != latency(0) || o.strb_low != ST || o.rdata !== exp_rdata) begin
      errors++; $display("FAIL rstmid_retry: got %0d/%0d/%h want %0d/%0d/%h",
        o.ack_idx, o.strb_low, o.rdata, latency(0), ST, exp_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int a1, a2, nack, aen_hi, slow;
    lat = latency(0);
    a1 = -1; a2 = -1; nack = 0; aen_hi = 0; slow = 0;
    @(negedge clk);
    bif.cpu_we = 1'b1; bif.cpu_io = 1'b0;
    bif.cpu_addr = 20'($urandom); bif.cpu_wdata = 8'($urandom);
    bif.cpu_req = 1'b1;
    for (int i = 0; i < 2 * lat + 5; i++) begin
      @(negedge clk);
      if (i == lat + 1) bif.cpu_req = 1'b0;
      if (bif.cpu_ack) begin
        nack++;
        if (a1 < 0) a1 = i; else a2 = i;
      end
      if (bif.bus_aen && i < 2 * lat + 1) aen_hi++;
      if (!bif.bus_memw_l) slow++;
    end
    checks++;
    if (nack != 2 || a1 != lat || a2 != 2 * lat + 1) begin
      errors++; $display("FAIL b2b_acks: got %0d at %0d,%0d want 2 at %0d,%0d",
        nack, a1, a2, lat, 2 * lat + 1);
    end
    checks++;
    if (aen_hi != 1 || slow != 2 * ST) begin
      errors++; $display("FAIL b2b_gap: got aen_hi %0d strobe %0d want 1 %0d",
        aen_hi, slow, 2 * ST);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_rdata = 8'h00;
    reset_n = 1'b0;
    bif.cpu_req = 1'b0; bif.cpu_we = 1'b0; bif.cpu_io = 1'b0;
    bif.cpu_addr = 20'h0; bif.cpu_wdata = 8'h0;
    bif.bus_in = 8'h00; bif.bus_rdy = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_mem_write;
    test_io_read;
    test_wait_states;
`ifdef BRIDGE_TIMEOUT_EN
    test_timeout;
`endif
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
